cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: start  input  1  leave IDLE and begin fetching.
REQ-004 SHALL have port: mem_rdata  input  8  memory read data, valid while mem_ack=1.
REQ-005 SHALL have port: mem_ack  input  1  memory transaction complete, sampled only while mem_req=1.
REQ-006 SHALL have port: r_val  input  8  value of the register selected by ir_reg, used for branch conditions.
REQ-007 SHALL have port: mem_req  output  1  memory transaction request.
REQ-008 SHALL have port: mem_we  output  1  transaction is a write (ST only).
REQ-009 SHALL have port: addr_sel  output  1  0 = address from pc, 1 = address from ir_operand_addr.
REQ-010 SHALL have port: repc  output  1  PC update enable to the PC/branch unit.
REQ-011 SHALL have port: inc  output  1  with repc: 1 = pc+1, 0 = pc+ir_operand_addr.
REQ-012 SHALL have port: ir_opcode  output  4  latched opcode.
REQ-013 SHALL have port: ir_reg  output  4  latched register field.
REQ-014 SHALL have port: ir_operand_addr  output  8  latched operand byte.
REQ-015 SHALL have port: reg_we  output  1  register file write strobe.
REQ-016 SHALL have port: halted  output  1  HALT executed.
REQ-017 SHALL have port: illegal  output  1  sticky, reserved opcode seen.
REQ-018 SHALL have port: retired  output  16  count of completed instructions.

Function
REQ-019 SHALL use opcodes: 0 NOP, 1 LD, 2 ST, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 MOV, 8 B, 9 BP, A BN, B BZ, C-E reserved, F HALT.
REQ-020 SHALL encode an instruction as two bytes: byte0 = {opcode[7:4], reg[3:0]}, byte1 = operand.
REQ-021 SHALL implement states IDLE, FETCH0, FETCH1, EXEC, MEM, BRANCH, HALT.
REQ-022 SHALL, in IDLE, drive all strobes low and move to FETCH0 on the first clock with start=1.
REQ-023 SHALL, in FETCH0 and FETCH1, hold mem_req=1, addr_sel=0, mem_we=0 until mem_ack is sampled high.
REQ-024 SHALL, in the ack cycle of FETCH0, latch mem_rdata[7:4] into ir_opcode and [3:0] into ir_reg, and go to FETCH1.
REQ-025 SHALL, in the ack cycle of FETCH1, latch mem_rdata into ir_operand_addr and go to EXEC.
REQ-026 SHALL assert repc=1 and inc=1 combinationally for exactly the ack cycle of FETCH0 and of FETCH1, so pc advances by 2 per instruction.
REQ-027 SHALL keep EXEC one cycle long, with these exits:
  - NOP → FETCH0
  - ADD/SUB/AND/OR/MOV → reg_we=1 for that cycle, then FETCH0
  - LD/ST → MEM
  - B/BP/BN/BZ → BRANCH
  - HALT → HALT
  - reserved → set illegal, then FETCH0 (treated as NOP)
REQ-028 SHALL, in MEM, hold mem_req=1, addr_sel=1 and mem_we=(opcode==ST) until ack; for LD, assert reg_we=1 in the ack cycle; then go to FETCH0.
REQ-029 SHALL evaluate the branch condition in BRANCH:
  - B: always taken
  - BP: taken when r_val[7]=0
  - BN: taken when r_val[7]=1
  - BZ: taken when r_val=8'h00
REQ-030 SHALL, in BRANCH, assert repc=1, inc=0 for one cycle if taken, else leave repc=0; then go to FETCH0.
REQ-031 SHALL keep repc=0 in every other state/cycle; inc is don't-care while repc=0 but SHALL be driven 0.
REQ-032 SHALL keep mem_we, addr_sel, and the memory address source stable while mem_req=1 and ack is not yet received.
REQ-033 SHALL ignore mem_ack whenever mem_req=0.
REQ-034 SHALL increment retired by 1 on each transition into FETCH0 from EXEC, MEM or BRANCH, and on entry to HALT.
REQ-035 SHALL wrap retired from 16'hFFFF to 16'h0000.
REQ-036 SHALL, in HALT, assert halted=1 and hold all strobes low; exit only by reset.
REQ-037 SHALL ignore start outside IDLE.

Reset
REQ-038 SHALL, on reset_n=0 at any time, asynchronously enter IDLE and clear every output and register:
  - clears: ir_*, retired, illegal, halted, all strobes
  - any in-flight memory transaction is abandoned.
REQ-039 SHALL, after reset_n deasserts, remain in IDLE until start=1.

Verification
REQ-040 SHALL cover: reset_n low mid-MEM with mem_req=1 → mem_req=0 immediately, state IDLE, retired=0.
REQ-041 SHALL cover: start, fetch bytes 0x35,0x00 with ack delayed 2 cycles each → two single-cycle repc/inc pulses, then reg_we=1 for one EXEC cycle, retired=1.
REQ-042 SHALL cover: BZ (0xB2,0x10) with r_val=0x00 → BRANCH repc=1, inc=0 one cycle; repeated with r_val=0x05 → repc stays 0.
REQ-043 SHALL cover: BP/BN with r_val=0x80 → BN taken, BP not taken.
REQ-044 SHALL cover: LD (0x13,0x40) → MEM mem_req=1, addr_sel=1, mem_we=0; reg_we=1 in the ack cycle; ST (0x23,0x41) → mem_we=1, no reg_we.
REQ-045 SHALL cover: byte0=0xC0 → illegal=1 sticky, execution continues; byte0=0xF0 → halted=1, no further mem_req.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Control sequencer for a two-byte-instruction CPU: fetches byte0/byte1, decodes,
// drives memory/PC/register-file strobes and counts retired instructions.
module cpu_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic [7:0]  r_val,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        repc,
    output logic        inc,
    output logic [3:0]  ir_opcode,
    output logic [3:0]  ir_reg,
    output logic [7:0]  ir_operand_addr,
    output logic        reg_we,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_B    = 4'h8;
    localparam logic [3:0] OP_BP   = 4'h9;
    localparam logic [3:0] OP_BN   = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_ir_opcode;
    logic [3:0]  r_ir_reg;
    logic [7:0]  r_ir_operand;
    logic [15:0] r_retired;
    logic        r_illegal;

    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_addr_sel;
    logic        w_repc;
    logic        w_inc;
    logic        w_reg_we;
    logic        w_ld_ir0;
    logic        w_ld_ir1;
    logic        w_retire;
    logic        w_set_illegal;

    function automatic logic branch_taken(input logic [3:0] op, input logic [7:0] val);
        logic taken;
        case (op)
            OP_B:    taken = 1'b1;
            OP_BP:   taken = ~val[7];
            OP_BN:   taken = val[7];
            OP_BZ:   taken = (val == 8'h00);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and combinational strobes; mem_ack only matters while requesting.
    always_comb begin
        w_next        = r_state;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_addr_sel    = 1'b0;
        w_repc        = 1'b0;
        w_inc         = 1'b0;
        w_reg_we      = 1'b0;
        w_ld_ir0      = 1'b0;
        w_ld_ir1      = 1'b0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH0;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH0: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    w_repc   = 1'b1;
                    w_inc    = 1'b1;
                    w_ld_ir0 = 1'b1;
                    w_next   = S_FETCH1;
                end else begin
                    w_next = S_FETCH0;
                end
            end
            S_FETCH1: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    w_repc   = 1'b1;
                    w_inc    = 1'b1;
                    w_ld_ir1 = 1'b1;
                    w_next   = S_EXEC;
                end else begin
                    w_next = S_FETCH1;
                end
            end
            S_EXEC: begin
                case (r_ir_opcode)
                    OP_NOP: begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH0;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: begin
                        w_reg_we = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH0;
                    end
                    OP_LD, OP_ST: begin
                        w_next = S_MEM;
                    end
                    OP_B, OP_BP, OP_BN, OP_BZ: begin
                        w_next = S_BRANCH;
                    end
                    OP_HALT: begin
                        w_retire = 1'b1;
                        w_next   = S_HALT;
                    end
                    default: begin
                        // Reserved opcodes flag illegal and otherwise behave as NOP.
                        w_set_illegal = 1'b1;
                        w_retire      = 1'b1;
                        w_next        = S_FETCH0;
                    end
                endcase
            end
            S_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (r_ir_opcode == OP_ST);
                if (mem_ack) begin
                    w_reg_we = (r_ir_opcode == OP_LD);
                    w_retire = 1'b1;
                    w_next   = S_FETCH0;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_BRANCH: begin
                w_repc   = branch_taken(r_ir_opcode, r_val);
                w_inc    = 1'b0;
                w_retire = 1'b1;
                w_next   = S_FETCH0;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Instruction register, retire counter and sticky illegal flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_opcode  <= 4'h0;
            r_ir_reg     <= 4'h0;
            r_ir_operand <= 8'h00;
            r_retired    <= 16'h0000;
            r_illegal    <= 1'b0;
        end else begin
            if (w_ld_ir0) begin
                r_ir_opcode <= mem_rdata[7:4];
                r_ir_reg    <= mem_rdata[3:0];
            end
            if (w_ld_ir1) begin
                r_ir_operand <= mem_rdata;
            end
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign mem_req         = w_mem_req;
    assign mem_we          = w_mem_we;
    assign addr_sel        = w_addr_sel;
    assign repc            = w_repc;
    assign inc             = w_inc;
    assign reg_we          = w_reg_we;
    assign ir_opcode       = r_ir_opcode;
    assign ir_reg          = r_ir_reg;
    assign ir_operand_addr = r_ir_operand;
    assign halted          = (r_state == S_HALT);
    assign illegal         = r_illegal;
    assign retired         = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: acts as memory and PC unit, runs directed and random
// programs and compares the observed bus/strobe event stream with an ISA-level model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [7:0]  r_val = 8'h00;
    logic        mem_req, mem_we, addr_sel, repc, inc, reg_we, halted, illegal;
    logic [3:0]  ir_opcode, ir_reg;
    logic [7:0]  ir_operand_addr;
    logic [15:0] retired;

    cpu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .r_val(r_val), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .repc(repc), .inc(inc), .ir_opcode(ir_opcode),
        .ir_reg(ir_reg), .ir_operand_addr(ir_operand_addr), .reg_we(reg_we),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    // Event kinds in the observed/expected streams, packed as (kind << 8) | byte.
    localparam int EV_FETCH = 1;
    localparam int EV_LOAD  = 2;
    localparam int EV_STORE = 3;
    localparam int EV_REGWE = 4;
    localparam int EV_JUMP  = 5;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [256];
    logic [7:0]  prog [$];
    int          exp_q [$];
    int          obs_q [$];
    int          fixed_delay = -1;
    logic [7:0]  pc_tb = 8'h00;
    int          bad_stab = 0;
    int          bad_fetch = 0;
    int          bad_inc = 0;
    int          bad_halt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ev(input int kind, input logic [7:0] a);
        return (kind << 8) | int'(a);
    endfunction

    function automatic int next_delay();
        if (fixed_delay >= 0) return fixed_delay;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    endtask

    // Instruction-set level model: walk the program and list the expected events.
    task automatic run_model(input logic [7:0] rv, output int n_ret, output bit ill);
        logic [7:0] pc, b0, b1;
        int op;
        bit taken, done;
        pc = 8'h00; n_ret = 0; ill = 1'b0; done = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 400 && !done; k++) begin
            b0 = mem[pc];
            b1 = mem[pc + 8'd1];
            exp_q.push_back(ev(EV_FETCH, pc));
            exp_q.push_back(ev(EV_FETCH, pc + 8'd1));
            pc = pc + 8'd2;
            op = int'(b0 >> 4);
            n_ret++;
            if (op >= 3 && op <= 7) exp_q.push_back(ev(EV_REGWE, b0 & 8'h0F));
            else if (op == 1) begin
                exp_q.push_back(ev(EV_LOAD, b1));
                exp_q.push_back(ev(EV_REGWE, b0 & 8'h0F));
            end else if (op == 2) exp_q.push_back(ev(EV_STORE, b1));
            else if (op >= 8 && op <= 11) begin
                taken = (op == 8) || (op == 9 && $signed(rv) >= 0) ||
                        (op == 10 && $signed(rv) < 0) || (op == 11 && rv == 8'h00);
                if (taken) begin
                    pc = pc + b1;
                    exp_q.push_back(ev(EV_JUMP, pc));
                end
            end else if (op == 15) done = 1'b1;
            else if (op >= 12) ill = 1'b1;
        end
    endtask

    // Memory responder and PC unit; also records what the sequencer did each cycle.
    initial begin
        int  cnt;
        bit  ack, prev_pend, p_we, p_sel;
        logic [7:0] addr, p_addr;
        cnt = 0; prev_pend = 1'b0; p_we = 1'b0; p_sel = 1'b0; p_addr = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pc_tb = 8'h00; obs_q.delete(); cnt = next_delay(); prev_pend = 1'b0;
                bad_stab = 0; bad_fetch = 0; bad_inc = 0; bad_halt = 0;
                mem_ack = 1'b0;
                continue;
            end
            if (mem_req) begin
                if (cnt == 0) ack = 1'b1;
                else begin ack = 1'b0; cnt--; end
            end else begin
                ack = 1'($urandom_range(0, 1));
            end
            addr = addr_sel ? ir_operand_addr : pc_tb;
            mem_rdata = (ack && mem_req) ? mem[addr] : 8'($urandom);
            mem_ack = ack;
            #1;
            if (prev_pend && !(mem_req && mem_we == p_we && addr_sel == p_sel && addr == p_addr))
                bad_stab++;
            prev_pend = mem_req && !mem_ack;
            p_we = mem_we; p_sel = addr_sel; p_addr = addr;
            if (mem_req && mem_ack) begin
                if (!addr_sel) obs_q.push_back(ev(EV_FETCH, addr));
                else if (mem_we) obs_q.push_back(ev(EV_STORE, addr));
                else obs_q.push_back(ev(EV_LOAD, addr));
                if (!addr_sel && !(repc && inc)) bad_fetch++;
                cnt = next_delay();
            end
            if (repc && inc && !(mem_req && mem_ack && !addr_sel)) bad_inc++;
            if (reg_we) obs_q.push_back(ev(EV_REGWE, {4'h0, ir_reg}));
            if (repc) pc_tb = inc ? pc_tb + 8'd1 : pc_tb + ir_operand_addr;
            if (repc && !inc) obs_q.push_back(ev(EV_JUMP, pc_tb));
            if (halted && mem_req) bad_halt++;
        end
    end

    task automatic run_program(input string name, input logic [7:0] rv, input int dly);
        int  n_ret, cyc, diff;
        bit  ill;
        load_prog();
        r_val = rv;
        fixed_delay = dly;
        run_model(rv, n_ret, ill);
        reset_n = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        #3;
        chk({name, ".idle_no_req"}, 32'(mem_req), 32'd0);
        start = 1'b1;
        @(negedge clk);
        #3 start = 1'($urandom_range(0, 1));
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(negedge clk);
            #3 start = 1'($urandom_range(0, 1));
            cyc++;
        end
        chk({name, ".halted"}, 32'(halted), 32'd1);
        repeat (5) @(negedge clk);
        #3 start = 1'b0;
        chk({name, ".retired"}, 32'(retired), 32'(n_ret));
        chk({name, ".illegal"}, 32'(illegal), 32'(ill));
        chk({name, ".n_events"}, 32'(obs_q.size()), 32'(exp_q.size()));
        diff = -1;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (diff < 0 && obs_q[i] != exp_q[i]) diff = i;
        chk({name, ".first_event_diff"}, 32'(diff), 32'hFFFF_FFFF);
        chk({name, ".req_stable"}, 32'(bad_stab), 32'd0);
        chk({name, ".fetch_repc_inc"}, 32'(bad_fetch), 32'd0);
        chk({name, ".stray_inc"}, 32'(bad_inc), 32'd0);
        chk({name, ".req_after_halt"}, 32'(bad_halt), 32'd0);
    endtask

    initial begin
        int  cyc, n;
        bit  seen;
        logic [3:0] op;
        logic [7:0] rvs [4];
        rvs[0] = 8'h00; rvs[1] = 8'h05; rvs[2] = 8'h80; rvs[3] = 8'h7F;

        repeat (3) @(negedge clk);
        #3;
        chk("reset.mem_req", 32'(mem_req), 32'd0);
        chk("reset.repc", 32'(repc), 32'd0);
        chk("reset.halted", 32'(halted), 32'd0);
        chk("reset.illegal", 32'(illegal), 32'd0);
        chk("reset.retired", 32'(retired), 32'd0);
        chk("reset.ir", {ir_opcode, ir_reg, ir_operand_addr}, 32'd0);

        // Reset while a load is waiting on its acknowledge.
        prog = '{8'h35, 8'h00, 8'h13, 8'h40};
        load_prog();
        fixed_delay = 4;
        reset_n = 1'b1;
        @(negedge clk);
        #3 start = 1'b1;
        @(negedge clk);
        #3 start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk);
            #2;
            if (mem_req && addr_sel) seen = 1'b1;
            cyc++;
        end
        chk("rstmem.in_mem", 32'(seen), 32'd1);
        chk("rstmem.retired_before", 32'(retired), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmem.mem_req", 32'(mem_req), 32'd0);
        chk("rstmem.retired", 32'(retired), 32'd0);
        chk("rstmem.ir_opcode", 32'(ir_opcode), 32'd0);
        @(negedge clk);
        #3 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        chk("rstmem.stays_idle", 32'(mem_req), 32'd0);

        prog = '{8'h35, 8'h00};
        run_program("add_dly2", 8'h00, 2);
        prog = '{8'hB2, 8'h10};
        run_program("bz_taken", 8'h00, -1);
        run_program("bz_not", 8'h05, -1);
        prog = '{8'h92, 8'h04, 8'hA2, 8'h04};
        run_program("bp_bn", 8'h80, -1);
        prog = '{8'h13, 8'h40, 8'h23, 8'h41};
        run_program("ld_st", 8'h00, -1);
        prog = '{8'hC0, 8'h00, 8'h35, 8'h00, 8'hE1, 8'h22, 8'h05, 8'h00};
        run_program("illegal", 8'h00, -1);

        for (int r = 0; r < 8; r++) begin
            prog.delete();
            n = $urandom_range(8, 20);
            for (int i = 0; i < n; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h3;
                prog.push_back({op, 4'($urandom)});
                if (op >= 4'h8 && op <= 4'hB) prog.push_back(8'(2 * $urandom_range(0, 3)));
                else prog.push_back(8'($urandom));
            end
            run_program($sformatf("rand%0d", r), rvs[$urandom_range(0, 3)], -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
